// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared I2C definitions: responder state encoding and the TMP101
//          default 7-bit address used by both master and target sides.
// Rev    : 1.0  initial release
// ============================================================================
package i2c_pkg;

   localparam logic [6:0] TMP101_ADDR = 7'b1001000;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      RX_BYTE   = 3'd3,
      RX_ACK    = 3'd4,
      TX_BYTE   = 3'd5,
      TX_ACKCHK = 3'd6,
      WAIT_STOP = 3'd7
   } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module : i2c_line_sync
// Brief  : SCL/SDA synchronizer with registered SCL edge and START/STOP
//          detection; sda_level is aligned with the event pulses.
// Rev    : 1.0  initial release
// ============================================================================
module i2c_line_sync #(
   parameter int SyncStages = 2
) (
   input  logic clock,
   input  logic Reset,
   input  logic scl_pin,
   input  logic sda_pin,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_level
);

   logic [SyncStages-1:0] scl_sync;
   logic [SyncStages-1:0] sda_sync;
   logic                  scl_prev;
   logic                  sda_prev;
   logic                  scl_now;
   logic                  sda_now;

   assign scl_now = scl_sync[SyncStages-1];
   assign sda_now = sda_sync[SyncStages-1];

   // Flops clear to 0 so both lines must be seen high before a START counts.
   always_ff @(posedge clock) begin
      if (Reset) begin
         scl_sync  <= '0;
         sda_sync  <= '0;
         scl_prev  <= 1'b0;
         sda_prev  <= 1'b0;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         sda_level <= 1'b0;
      end else begin
         scl_sync  <= {scl_sync[SyncStages-2:0], scl_pin};
         sda_sync  <= {sda_sync[SyncStages-2:0], sda_pin};
         scl_prev  <= scl_now;
         sda_prev  <= sda_now;
         scl_rise  <= scl_now & ~scl_prev;
         scl_fall  <= ~scl_now & scl_prev;
         start_det <= scl_now & scl_prev & sda_prev & ~sda_now;
         stop_det  <= scl_now & scl_prev & ~sda_prev & sda_now;
         sda_level <= sda_now;
      end
   end

endmodule
`default_nettype wire

// File: rtl/i2c_target_responder.sv
`default_nettype none
// ============================================================================
// Module : i2c_target_responder
// Brief  : I2C target standing in for a TMP101: ACKs its address, accepts
//          write bytes, returns a 16-bit register on reads. Open-drain SDA.
//          Define I2C_GENERAL_CALL_EN to also ACK address byte 8'h00.
// Rev    : 1.0  initial release
// ============================================================================
module i2c_target_responder
   import i2c_pkg::*;
#(
   parameter logic [6:0] SlaveAddress = TMP101_ADDR,
   parameter int         SyncStages   = 2
) (
   input  logic        clock,
   input  logic        Reset,
   input  logic        SCL,
   inout  wire         SDA,
   input  logic [15:0] TxData,
   output logic [7:0]  RxData,
   output logic        RxValid,
   output logic        AddrMatch,
   output logic        Busy
);

   logic        scl_rise;
   logic        scl_fall;
   logic        start_det;
   logic        stop_det;
   logic        sda_level;

   state_t      state;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift;
   logic [15:0] tx_reg;
   logic        byte_sel;
   logic        is_read;
   logic        ack_seen;
   logic        sda_low;
   logic        addr_hit;
   logic        gen_call;

   i2c_line_sync #(
      .SyncStages (SyncStages)
   ) u_line_sync (
      .clock     (clock),
      .Reset     (Reset),
      .scl_pin   (SCL),
      .sda_pin   (SDA),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_level (sda_level)
   );

   assign SDA      = sda_low ? 1'b0 : 1'bz;
   assign addr_hit = (shift[7:1] == SlaveAddress);
`ifdef I2C_GENERAL_CALL_EN
   assign gen_call = (shift == 8'h00);
`else
   assign gen_call = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (Reset) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shift     <= 8'h00;
         tx_reg    <= 16'h0000;
         byte_sel  <= 1'b0;
         is_read   <= 1'b0;
         ack_seen  <= 1'b0;
         sda_low   <= 1'b0;
         RxData    <= 8'h00;
         RxValid   <= 1'b0;
         AddrMatch <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         RxValid   <= 1'b0;
         AddrMatch <= 1'b0;
         if (start_det) begin
            state   <= ADDR;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            sda_low <= 1'b0;
            Busy    <= 1'b1;
         end else if (stop_det) begin
            state   <= IDLE;
            sda_low <= 1'b0;
            Busy    <= 1'b0;
         end else begin
            case (state)
               ADDR, RX_BYTE: begin
                  if (scl_rise) begin
                     shift   <= {shift[6:0], sda_level};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        state <= (state == ADDR) ? ADDR_ACK : RX_ACK;
                  end
               end
               // sda_low marks the second half: the fall that ends the ACK clock.
               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (sda_low) begin
                        sda_low <= is_read ? ~tx_reg[15] : 1'b0;
                        state   <= is_read ? TX_BYTE : RX_BYTE;
                        bit_cnt <= 3'd0;
                     end else if (addr_hit || gen_call) begin
                        sda_low   <= 1'b1;
                        AddrMatch <= 1'b1;
                        is_read   <= shift[0];
                        tx_reg    <= TxData;
                        byte_sel  <= 1'b0;
                     end else begin
                        state <= WAIT_STOP;
                     end
                  end
               end
               RX_ACK: begin
                  if (scl_fall) begin
                     if (sda_low) begin
                        sda_low <= 1'b0;
                        state   <= RX_BYTE;
                     end else begin
                        sda_low <= 1'b1;
                        RxData  <= shift;
                        RxValid <= 1'b1;
                     end
                  end
               end
               TX_BYTE: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state    <= TX_ACKCHK;
                        ack_seen <= 1'b0;
                     end
                  end else if (scl_fall) begin
                     tx_reg  <= {tx_reg[14:0], 1'b0};
                     sda_low <= ~tx_reg[14];
                  end
               end
               // First fall releases SDA and lines up the next byte; after a
               // master ACK the following fall drives its MSB.
               TX_ACKCHK: begin
                  if (scl_rise) begin
                     if (sda_level)
                        state <= WAIT_STOP;
                     else
                        ack_seen <= 1'b1;
                  end else if (scl_fall) begin
                     if (ack_seen) begin
                        sda_low <= ~tx_reg[15];
                        state   <= TX_BYTE;
                        bit_cnt <= 3'd0;
                     end else begin
                        sda_low  <= 1'b0;
                        tx_reg   <= byte_sel ? TxData : {tx_reg[14:0], 1'b0};
                        byte_sel <= ~byte_sel;
                     end
                  end
               end
               IDLE, WAIT_STOP: begin
                  sda_low <= 1'b0;
               end
               default: begin
                  state   <= IDLE;
                  sda_low <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_i2c_target_responder
// Brief  : Bit-banged I2C master with a queue scoreboard and transaction-level
//          reference model for i2c_target_responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_i2c_target_responder;

   localparam int         HALF = 20;
   localparam logic [6:0] OWN  = 7'b1001000;
`ifdef I2C_GENERAL_CALL_EN
   localparam bit GC_EN = 1'b1;
`else
   localparam bit GC_EN = 1'b0;
`endif

   typedef enum int {K_AM, K_RX, K_ACK, K_BYTE} kind_t;
   typedef struct {
      kind_t      kind;
      logic [7:0] val;
   } ev_t;

   logic        clock = 1'b0;
   logic        Reset = 1'b1;
   logic        scl = 1'b1;
   logic        sda_drv_low = 1'b0;
   logic [15:0] tx_data = 16'h0000;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        addr_match;
   logic        busy;
   wire         sda;

   ev_t pulse_q[$];
   ev_t bus_q[$];
   ev_t obs_q[$];
   int  n_checks = 0;
   int  n_fail = 0;

   pullup (sda);
   assign sda = sda_drv_low ? 1'b0 : 1'bz;

   always #5 clock = ~clock;

   i2c_target_responder dut (
      .clock     (clock),
      .Reset     (Reset),
      .SCL       (scl),
      .SDA       (sda),
      .TxData    (tx_data),
      .RxData    (rx_data),
      .RxValid   (rx_valid),
      .AddrMatch (addr_match),
      .Busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Monitor: compares DUT pulses and master observations against the queues.
   initial begin
      ev_t e;
      ev_t o;
      forever begin
         @(negedge clock);
         if (addr_match) begin
            if (pulse_q.size() == 0) check("unexpected_addr_match", 1, 0);
            else begin
               e = pulse_q.pop_front();
               check("addr_match_kind", e.kind, K_AM);
            end
            check("sda_low_at_addr_match", sda, 1'b0);
         end
         if (rx_valid) begin
            if (pulse_q.size() == 0) check("unexpected_rx_valid", 1, 0);
            else begin
               e = pulse_q.pop_front();
               check("rx_valid_kind", e.kind, K_RX);
               check("rx_data", rx_data, e.val);
            end
            check("sda_low_at_rx_valid", sda, 1'b0);
         end
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (bus_q.size() == 0) check("unexpected_bus_obs", 1, 0);
            else begin
               e = bus_q.pop_front();
               check("bus_kind", o.kind, e.kind);
               check(o.kind == K_ACK ? "target_ack_bit" : "read_byte", o.val, e.val);
            end
         end
      end
   end

   task automatic bit_xfer(input logic b, output logic rd);
      sda_drv_low = (b == 1'b0);
      clks(HALF);
      scl = 1'b1;
      clks(HALF);
      rd  = sda;
      scl = 1'b0;
      clks(4);
   endtask

   task automatic bus_start(input bit repeated);
      sda_drv_low = 1'b0;
      if (repeated) begin
         clks(HALF);
         scl = 1'b1;
      end else begin
         scl = 1'b1;
      end
      clks(HALF);
      sda_drv_low = 1'b1;
      clks(HALF);
      scl = 1'b0;
      clks(4);
      check("busy_after_start", busy, 1'b1);
   endtask

   task automatic bus_stop();
      sda_drv_low = 1'b1;
      clks(HALF);
      scl = 1'b1;
      clks(HALF);
      sda_drv_low = 1'b0;
      clks(HALF);
      check("busy_after_stop", busy, 1'b0);
      check("sda_released_after_stop", sda, 1'b1);
   endtask

   task automatic write_byte(input logic [7:0] b);
      logic [7:0] echo;
      logic       ack;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], echo[i]);
      check("write_bits_not_disturbed", echo, b);
      bit_xfer(1'b1, ack);
      obs_q.push_back('{K_ACK, {7'b0, ack}});
   endtask

   task automatic read_byte(input bit master_ack);
      logic [7:0] val;
      logic       rd;
      for (int i = 7; i >= 0; i--) bit_xfer(1'b1, val[i]);
      obs_q.push_back('{K_BYTE, val});
      bit_xfer(master_ack ? 1'b0 : 1'b1, rd);
      check("master_ack_seen_on_bus", rd, master_ack ? 1'b0 : 1'b1);
   endtask

   // Reference model: target ACKs its own address (and general call if enabled);
   // reads return TxData high/low bytes, pairs latched at the start of each pair.
   task automatic do_txn(input logic [7:0] addr, input int nbytes, input logic [7:0] first,
                         input bit rstart, input bit end_stop, input bit vary_tx);
      bit          acked;
      logic [15:0] latched;
      logic [7:0]  b;
      acked = (addr[7:1] == OWN) || (GC_EN && addr == 8'h00);
      latched = tx_data;
      bus_start(rstart);
      bus_q.push_back('{K_ACK, acked ? 8'h00 : 8'h01});
      if (acked) pulse_q.push_back('{K_AM, 8'h00});
      write_byte(addr);
      if (!acked) begin
         for (int k = 0; k < nbytes; k++) begin
            bus_q.push_back('{K_ACK, 8'h01});
            write_byte(8'($urandom));
         end
         check("busy_in_wait_stop", busy, 1'b1);
      end else if (addr[0] == 1'b0) begin
         for (int k = 0; k < nbytes; k++) begin
            b = (k == 0) ? first : 8'($urandom);
            bus_q.push_back('{K_ACK, 8'h00});
            pulse_q.push_back('{K_RX, b});
            write_byte(b);
         end
      end else begin
         for (int k = 0; k < nbytes; k++) begin
            if (k % 2 == 0) begin
               latched = tx_data;
               bus_q.push_back('{K_BYTE, latched[15:8]});
            end else begin
               bus_q.push_back('{K_BYTE, latched[7:0]});
               if (vary_tx) tx_data = 16'($urandom);
            end
            read_byte(k != nbytes - 1);
         end
      end
      if (end_stop) bus_stop();
   endtask

   initial begin
      logic [7:0] a;
      int         r;
      clks(5);
      check("reset_sda", sda, 1'b1);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_addr_match", addr_match, 1'b0);
      check("reset_busy", busy, 1'b0);
      Reset = 1'b0;
      clks(10);

      tx_data = 16'h1A50;
      do_txn(8'h91, 2, 8'h00, 1'b0, 1'b1, 1'b0);
      do_txn(8'h90, 1, 8'h01, 1'b0, 1'b1, 1'b0);
      check("rx_data_held", rx_data, 8'h01);
      do_txn(8'h92, 2, 8'h00, 1'b0, 1'b1, 1'b0);
      tx_data = 16'hABCD;
      do_txn(8'h91, 4, 8'h00, 1'b0, 1'b1, 1'b0);
      do_txn(8'h90, 1, 8'h00, 1'b0, 1'b0, 1'b0);
      tx_data = 16'h3C77;
      do_txn(8'h91, 1, 8'h00, 1'b1, 1'b1, 1'b0);
      do_txn(8'h00, 1, 8'h6E, 1'b0, 1'b1, 1'b0);
      do_txn(8'h90, 1, 8'h5A, 1'b0, 1'b1, 1'b0);

      // Reset while the target drives the MSB (0) of 8'h1A.
      tx_data = 16'h1A50;
      bus_start(1'b0);
      bus_q.push_back('{K_ACK, 8'h00});
      pulse_q.push_back('{K_AM, 8'h00});
      write_byte(8'h91);
      clks(6);
      check("tx_msb_driven_low", sda, 1'b0);
      Reset = 1'b1;
      clks(1);
      check("midtx_reset_sda", sda, 1'b1);
      check("midtx_reset_rx_data", rx_data, 8'h00);
      check("midtx_reset_busy", busy, 1'b0);
      check("midtx_reset_addr_match", addr_match, 1'b0);
      check("midtx_reset_rx_valid", rx_valid, 1'b0);
      Reset = 1'b0;
      bus_stop();
      clks(HALF);

      for (int t = 0; t < 10; t++) begin
         r = $urandom_range(0, 3);
         case (r)
            0: a = {OWN, 1'b1};
            1: a = {OWN, 1'b0};
            2: begin
               a = 8'($urandom);
               while (a[7:1] == OWN || a == 8'h00) a = 8'($urandom);
            end
            default: a = 8'h00;
         endcase
         tx_data = 16'($urandom);
         do_txn(a, $urandom_range(1, 4), 8'($urandom), 1'b0, 1'b1, 1'b1);
      end

      clks(20);
      check("pulse_q_drained", pulse_q.size(), 0);
      check("bus_q_drained", bus_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
